// File: rtl/stk_pipe_mem_bnk.sv
// rtl/stk_pipe_mem_bnk.sv - banked prev-pointer/line SRAM stage with write buffer and read forwarding
//
// Purpose:
//   Holds BANKS_N single-port SRAMs of {prev_ptr, dat}. Serves one lookup read
//   per cycle (never stalled) and accepts writeback writes. A write that loses
//   its bank to a read is parked in a one-entry per-bank write buffer, drained
//   on the first cycle the bank is not read, and forwarded to matching reads.
//   Results reach the WRBK stage RD_LAT cycles after issue with the uc
//   sideband fields piped alongside.
//
// Ports:
//   clk, arst_n                      clock, asynchronous active-low reset
//   i_uc_*                           lookup read request and sideband
//   i_wr_vld / o_wr_rdy / i_wr_*     write request handshake and payload
//   o_wrbk_uc_*                      delayed valid and sideband
//   o_wrbk_prev_ptr / o_wrbk_dat     read result
//   o_wrbk_fwd                       result taken from the write buffer
//   o_par_err                        parity error on an SRAM-sourced result
//
// Optional feature macro: STK_PIPE_MEM_BNK_PARITY_EN
//   Defined: one even-parity bit per SRAM entry over {prev_ptr, dat}.
//   Undefined: no parity storage, o_par_err is constant 0.
module stk_pipe_mem_bnk #(
   parameter int BANKS_N = 4,
   parameter int LINES_N = 256,
   parameter int PTR_W   = 8,
   parameter int DAT_W   = 128,
   parameter int ENGID_W = 2,
   parameter int RD_LAT  = 1
) (
   input  logic                       clk,
   input  logic                       arst_n,
   input  logic                       i_uc_vld,
   input  logic [ENGID_W-1:0]         i_uc_engid,
   input  logic [$clog2(BANKS_N)-1:0] i_uc_bankid,
   input  logic [$clog2(LINES_N)-1:0] i_uc_line,
   input  logic                       i_uc_head_vld,
   input  logic [PTR_W-1:0]           i_uc_head_ptr,
   input  logic                       i_uc_tail_vld,
   input  logic [PTR_W-1:0]           i_uc_tail_ptr,
   input  logic                       i_wr_vld,
   output logic                       o_wr_rdy,
   input  logic [$clog2(BANKS_N)-1:0] i_wr_bankid,
   input  logic [$clog2(LINES_N)-1:0] i_wr_line,
   input  logic [PTR_W-1:0]           i_wr_prev_ptr,
   input  logic [DAT_W-1:0]           i_wr_dat,
   output logic                       o_wrbk_uc_vld,
   output logic [ENGID_W-1:0]         o_wrbk_uc_engid,
   output logic                       o_wrbk_uc_head_vld,
   output logic [PTR_W-1:0]           o_wrbk_uc_head_ptr,
   output logic                       o_wrbk_uc_tail_vld,
   output logic [PTR_W-1:0]           o_wrbk_uc_tail_ptr,
   output logic [PTR_W-1:0]           o_wrbk_prev_ptr,
   output logic [DAT_W-1:0]           o_wrbk_dat,
   output logic                       o_wrbk_fwd,
   output logic                       o_par_err
);

   localparam int BK_W   = $clog2(BANKS_N);
   localparam int LN_W   = $clog2(LINES_N);
   localparam int EW     = PTR_W + DAT_W;
   localparam int SIDE_W = ENGID_W + 2 + 2 * PTR_W;
   localparam int PW     = SIDE_W + EW + 2;

   // Write buffer, one entry per bank
   logic [BANKS_N-1:0] wbuf_vld_q;
   logic [LN_W-1:0]    wbuf_line_q [BANKS_N];
   logic [PTR_W-1:0]   wbuf_ptr_q  [BANKS_N];
   logic [DAT_W-1:0]   wbuf_dat_q  [BANKS_N];

   // SRAM arrays and their read registers
   logic [EW-1:0]      mem_q [BANKS_N][LINES_N];
   logic [EW-1:0]      rd_q  [BANKS_N];
`ifdef STK_PIPE_MEM_BNK_PARITY_EN
   logic               mem_par_q [BANKS_N][LINES_N];
   logic               rd_par_q  [BANKS_N];
`endif

   // Per-bank port arbitration
   logic               wr_acc;
   logic [BANKS_N-1:0] rd_sel, wr_sel, drain, cap, mem_we;
   logic [LN_W-1:0]    mem_wa [BANKS_N];
   logic [EW-1:0]      mem_wd [BANKS_N];

   // First pipeline stage (SRAM read data stage)
   logic               s1_vld_q;
   logic [BK_W-1:0]    s1_bank_q;
   logic [SIDE_W-1:0]  s1_side_q;
   logic               s1_fwd_q;
   logic [PTR_W-1:0]   s1_fptr_q;
   logic [DAT_W-1:0]   s1_fdat_q;
   logic [EW-1:0]      rd_ent;
   logic [PTR_W-1:0]   s1_ptr;
   logic [DAT_W-1:0]   s1_dat;
   logic               s1_perr;
   logic [PW-1:0]      s1_pay;
   logic               rd_hit;

   logic               out_vld;
   logic [PW-1:0]      out_pay;
   logic               out_perr;

   // A bank holding a buffered write refuses further writes, which keeps
   // per-bank write order intact.
   assign o_wr_rdy = ~wbuf_vld_q[i_wr_bankid];
   assign wr_acc   = i_wr_vld & o_wr_rdy;
   assign rd_hit   = wbuf_vld_q[i_uc_bankid] && (wbuf_line_q[i_uc_bankid] == i_uc_line);

   always_comb begin
      rd_sel = '0;
      wr_sel = '0;
      drain  = '0;
      cap    = '0;
      mem_we = '0;
      for (int b = 0; b < BANKS_N; b++) begin
         mem_wa[b] = i_wr_line;
         mem_wd[b] = {i_wr_prev_ptr, i_wr_dat};
         rd_sel[b] = i_uc_vld && (i_uc_bankid == BK_W'(b));
         wr_sel[b] = wr_acc && (i_wr_bankid == BK_W'(b));
         // Read owns the port; a write arriving with it is parked.
         cap[b]    = rd_sel[b] && wr_sel[b];
         // Drain wins over a direct write; an accepted write to a bank with a
         // full buffer cannot happen, so both never compete.
         drain[b]  = !rd_sel[b] && wbuf_vld_q[b];
         mem_we[b] = drain[b] || (!rd_sel[b] && wr_sel[b]);
         if (drain[b]) begin
            mem_wa[b] = wbuf_line_q[b];
            mem_wd[b] = {wbuf_ptr_q[b], wbuf_dat_q[b]};
         end
      end
   end

   // SRAM storage: contents are deliberately not reset
   always_ff @(posedge clk) begin
      for (int b = 0; b < BANKS_N; b++) begin
         if (mem_we[b]) begin
            mem_q[b][mem_wa[b]] <= mem_wd[b];
`ifdef STK_PIPE_MEM_BNK_PARITY_EN
            mem_par_q[b][mem_wa[b]] <= ^mem_wd[b];
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         wbuf_vld_q <= '0;
         s1_vld_q   <= 1'b0;
         s1_bank_q  <= '0;
         s1_side_q  <= '0;
         s1_fwd_q   <= 1'b0;
         s1_fptr_q  <= '0;
         s1_fdat_q  <= '0;
         for (int b = 0; b < BANKS_N; b++) begin
            wbuf_line_q[b] <= '0;
            wbuf_ptr_q[b]  <= '0;
            wbuf_dat_q[b]  <= '0;
            rd_q[b]        <= '0;
`ifdef STK_PIPE_MEM_BNK_PARITY_EN
            rd_par_q[b]    <= 1'b0;
`endif
         end
      end else begin
         for (int b = 0; b < BANKS_N; b++) begin
            if (rd_sel[b]) begin
               rd_q[b] <= mem_q[b][i_uc_line];
`ifdef STK_PIPE_MEM_BNK_PARITY_EN
               rd_par_q[b] <= mem_par_q[b][i_uc_line];
`endif
            end
            if (cap[b]) begin
               wbuf_vld_q[b]  <= 1'b1;
               wbuf_line_q[b] <= i_wr_line;
               wbuf_ptr_q[b]  <= i_wr_prev_ptr;
               wbuf_dat_q[b]  <= i_wr_dat;
            end else if (drain[b]) begin
               wbuf_vld_q[b]  <= 1'b0;
            end
         end
         s1_vld_q <= i_uc_vld;
         // Forward data is sampled from the buffer state seen by the read, so
         // a same-cycle write to the same line is not visible (read-first).
         if (i_uc_vld) begin
            s1_bank_q <= i_uc_bankid;
            s1_side_q <= {i_uc_engid, i_uc_head_vld, i_uc_head_ptr, i_uc_tail_vld, i_uc_tail_ptr};
            s1_fwd_q  <= rd_hit;
            s1_fptr_q <= wbuf_ptr_q[i_uc_bankid];
            s1_fdat_q <= wbuf_dat_q[i_uc_bankid];
         end
      end
   end

   assign rd_ent = rd_q[s1_bank_q];
   assign s1_ptr = s1_fwd_q ? s1_fptr_q : rd_ent[EW-1:DAT_W];
   assign s1_dat = s1_fwd_q ? s1_fdat_q : rd_ent[DAT_W-1:0];
`ifdef STK_PIPE_MEM_BNK_PARITY_EN
   assign s1_perr = !s1_fwd_q && (rd_par_q[s1_bank_q] ^ (^rd_ent));
`else
   assign s1_perr = 1'b0;
`endif
   assign s1_pay = {s1_side_q, s1_ptr, s1_dat, s1_fwd_q, s1_perr};

   // Extra output stages load only on valid so data fields hold when idle
   generate
      if (RD_LAT == 1) begin : g_lat1
         assign out_vld = s1_vld_q;
         assign out_pay = s1_pay;
      end else begin : g_latn
         logic [RD_LAT-2:0] stg_vld_q;
         logic [PW-1:0]     stg_pay_q [RD_LAT-1];
         always_ff @(posedge clk or negedge arst_n) begin
            if (!arst_n) begin
               stg_vld_q <= '0;
               for (int i = 0; i < RD_LAT - 1; i++) stg_pay_q[i] <= '0;
            end else begin
               stg_vld_q[0] <= s1_vld_q;
               if (s1_vld_q) stg_pay_q[0] <= s1_pay;
               for (int i = 1; i < RD_LAT - 1; i++) begin
                  stg_vld_q[i] <= stg_vld_q[i-1];
                  if (stg_vld_q[i-1]) stg_pay_q[i] <= stg_pay_q[i-1];
               end
            end
         end
         assign out_vld = stg_vld_q[RD_LAT-2];
         assign out_pay = stg_pay_q[RD_LAT-2];
      end
   endgenerate

   assign o_wrbk_uc_vld = out_vld;
   assign {o_wrbk_uc_engid, o_wrbk_uc_head_vld, o_wrbk_uc_head_ptr, o_wrbk_uc_tail_vld,
           o_wrbk_uc_tail_ptr, o_wrbk_prev_ptr, o_wrbk_dat, o_wrbk_fwd, out_perr} = out_pay;
   assign o_par_err = out_vld & out_perr;

   a_rd_line: assert property (@(posedge clk) disable iff (!arst_n)
      i_uc_vld |-> (32'(i_uc_line) < 32'(LINES_N)));
   a_wr_line: assert property (@(posedge clk) disable iff (!arst_n)
      i_wr_vld |-> (32'(i_wr_line) < 32'(LINES_N)));

endmodule

// File: doc/stk_pipe_mem_bnk.md
Name: stk_pipe_mem_bnk

Overview:
- Parametrised next-generation memory stage of the stk pipeline. Owns per-bank single-port SRAMs holding prev-pointer and line data.
- Serves one lookup read per cycle from the LK stage and accepts writes from the writeback path, with a per-bank write buffer and read forwarding.
- Returns bank-muxed read data aligned with the microcode to the WRBK stage after a configurable latency.

Parameters:
- BANKS_N, 4, number of banks (power of 2, ≥2)
- LINES_N, 256, lines per bank
- PTR_W, 8, prev-pointer width
- DAT_W, 128, data line width
- ENGID_W, 2, engine id width
- RD_LAT, 1, cycles from uc issue to WRBK output (1..3)

Ports:
- clk  in  1  clock
- arst_n  in  1  asynchronous active-low reset
- i_uc_vld  in  1  lookup read valid; never stalled
- i_uc_engid  in  ENGID_W  engine id, passed through
- i_uc_bankid  in  log2(BANKS_N)  read bank
- i_uc_line  in  log2(LINES_N)  read line
- i_uc_head_vld/i_uc_tail_vld  in  1 each  passed through
- i_uc_head_ptr/i_uc_tail_ptr  in  PTR_W each  passed through
- i_wr_vld  in  1  write request
- o_wr_rdy  out  1  write accepted when i_wr_vld&o_wr_rdy
- i_wr_bankid  in  log2(BANKS_N)  write bank
- i_wr_line  in  log2(LINES_N)  write line
- i_wr_prev_ptr  in  PTR_W  prev-pointer to store
- i_wr_dat  in  DAT_W  data to store
- o_wrbk_uc_vld  out  1  read result valid
- o_wrbk_uc_engid, o_wrbk_uc_head_vld/ptr, o_wrbk_uc_tail_vld/ptr  out  as inputs  delayed pass-through
- o_wrbk_prev_ptr  out  PTR_W  read prev-pointer
- o_wrbk_dat  out  DAT_W  read data
- o_wrbk_fwd  out  1  result sourced from write buffer
- o_par_err  out  1  parity error (optional feature)

Behaviour:
- Reset:
  - All wbuf_vld and pipeline valids clear.
  - All outputs 0, except o_wr_rdy=1.
  - SRAM contents are not reset. Reset mid-operation drops buffered writes and in-flight reads.
- Per-bank arbitration each cycle, in priority order:
  1. Read (i_uc_vld && bankid==b).
  2. Drain wbuf[b] into SRAM.
  3. Direct write of the accepted incoming write.
- o_wr_rdy = !wbuf_vld[i_wr_bankid]. Combinational on i_wr_bankid; permitted, documented.
- Accepted write to bank b:
  - If b is not read this cycle, write SRAM directly.
  - Otherwise capture into wbuf[b] (line, ptr, dat) and set wbuf_vld[b].
- wbuf[b] drains in the first cycle bank b is not read; wbuf_vld[b] clears at that edge. A new write to b is not accepted while wbuf_vld[b]=1, so write ordering per bank is preserved.
- Forwarding:
  - A read whose bank/line matches a valid wbuf entry (state at the read cycle) returns wbuf ptr/dat and sets o_wrbk_fwd=1.
  - A read and an accepted write to the same bank/line in the same cycle: the read returns the prior contents (read-first); the write goes to wbuf.
- Latency:
  - SRAM read data is available 1 cycle after issue; RD_LAT-1 further register stages follow.
  - Bank mux select is the piped bankid; all uc sideband fields are piped with the valid.
  - o_wrbk_uc_vld asserts exactly RD_LAT cycles after i_uc_vld. Data fields hold their last value when vld=0.
- Starvation: continuous reads to bank b hold wbuf[b] indefinitely, and o_wr_rdy stays low for b. Other banks are unaffected.
- Line indices beyond LINES_N-1 are illegal (assertion).

Optional Feature:
- Macro: STK_PIPE_MEM_BNK_PARITY_EN.
- Defined:
  - Each SRAM entry stores one even-parity bit over {prev_ptr,dat}, computed on write (direct or drain).
  - On read, parity is checked on SRAM-sourced results only; forwarded results are never flagged.
  - o_par_err pulses with o_wrbk_uc_vld for the erroneous result.
- Undefined: no parity storage; o_par_err tied 0.

Test Plan:
- Reset then idle: o_wrbk_uc_vld=0, o_wr_rdy=1, o_par_err=0, wbuf empty.
- Write bank1 line5 ptr=0x3C dat=0xA5..; next cycle read bank1 line5 (RD_LAT=1) -> 1 cycle later vld=1, prev_ptr=0x3C, dat=0xA5.., fwd=0; engid/head/tail echoed.
- Same cycle: read bank2 line7 and write bank2 line7 ptr=0x11 (old 0x22) -> read returns 0x22; next-cycle read of bank2 line7 (bank busy) returns 0x11 with fwd=1.
- Reads to bank0 for 4 cycles plus write to bank0 in cycle 0 -> o_wr_rdy for bank0 low in cycles 1-4; drain occurs in cycle 4; rdy returns high in cycle 5; writes to bank3 are accepted meanwhile.
- RD_LAT=3, back-to-back reads across banks 0..3 -> results in order 3 cycles after each issue, correct bank muxing.
- PARITY_EN: corrupt a stored bit via backdoor, read -> o_par_err=1 with vld; forwarded read of the same line -> o_par_err=0.
